// File: rtl/i_cache_dm.sv
// Direct-mapped, single-word-line instruction cache between the CPU sram-like
// port and the bridge's instruction port. Optional hit/miss counters: I_CACHE_STAT_EN.
module i_cache_dm #(
  parameter int INDEX_WIDTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        no_cache,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok
`ifdef I_CACHE_STAT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT} state_t;
  state_t state, state_nxt;

  logic [31:0]          req_addr;
  logic [1:0]           req_size;
  logic                 req_nc;
  logic [LINES-1:0]     valid;
  logic [TAG_WIDTH-1:0] tag_arr  [LINES];
  logic [31:0]          data_arr [LINES];

  logic [INDEX_WIDTH-1:0] idx;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   hit, miss_done, fill;
  logic                   unused_ok;

  assign idx     = req_addr[INDEX_WIDTH+1:2];
  assign req_tag = req_addr[31:INDEX_WIDTH+2];
  assign unused_ok = ^{cpu_inst_wr, cpu_inst_wdata};

  // Uncached fetches are excluded from the hit term so they always go downstream.
  assign hit       = (state == LOOKUP) && !req_nc && valid[idx] && (tag_arr[idx] == req_tag);
  // Completion may coincide with addr_ok while still in MISS_REQ.
  assign miss_done = cache_inst_data_ok &&
                     ((state == MISS_WAIT) || ((state == MISS_REQ) && cache_inst_addr_ok));
  assign fill      = miss_done && !req_nc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (cpu_inst_req) state_nxt = LOOKUP;
      LOOKUP:    state_nxt = hit ? IDLE : MISS_REQ;
      MISS_REQ:  if (cache_inst_addr_ok) state_nxt = cache_inst_data_ok ? IDLE : MISS_WAIT;
      MISS_WAIT: if (cache_inst_data_ok) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_inst_addr_ok = (state == IDLE) && cpu_inst_req && !rst;
    cpu_inst_data_ok = hit || miss_done;
    cpu_inst_rdata   = '0;
    if (hit)            cpu_inst_rdata = data_arr[idx];
    else if (miss_done) cpu_inst_rdata = cache_inst_rdata;
    cache_inst_req   = (state == MISS_REQ);
  end

  assign cache_inst_wr    = 1'b0;
  assign cache_inst_wdata = '0;
  assign cache_inst_addr  = req_addr;
  assign cache_inst_size  = req_size;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr <= '0;
      req_size <= '0;
      req_nc   <= 1'b0;
    end else if (state == IDLE && cpu_inst_req) begin
      req_addr <= cpu_inst_addr;
      req_size <= cpu_inst_size;
      req_nc   <= no_cache;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       valid      <= '0;
    else if (fill) valid[idx] <= 1'b1;
  end

  // Tag/data need no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_arr[idx]  <= req_tag;
      data_arr[idx] <= cache_inst_rdata;
    end
  end

`ifdef I_CACHE_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && hit_cnt != '1)        hit_cnt  <= hit_cnt + 32'd1;
      if (miss_done && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_i_cache_dm.sv
// Directed bench for i_cache_dm: cold miss, hit, conflict eviction, uncached
// pass-through, stalled addr_ok, same-cycle addr_ok/data_ok, reset mid-miss.
module tb_i_cache_dm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        no_cache = 1'b0;
  logic        cpu_inst_req = 1'b0;
  logic        cpu_inst_wr = 1'b0;
  logic [1:0]  cpu_inst_size = 2'd2;
  logic [31:0] cpu_inst_addr = '0;
  logic [31:0] cpu_inst_wdata = '0;
  logic [31:0] cpu_inst_rdata;
  logic        cpu_inst_addr_ok, cpu_inst_data_ok;
  logic        cache_inst_req, cache_inst_wr;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr, cache_inst_wdata;
  logic [31:0] cache_inst_rdata = '0;
  logic        cache_inst_addr_ok = 1'b0;
  logic        cache_inst_data_ok = 1'b0;

  int checks = 0;
  int passes = 0;

  i_cache_dm dut (
    .clk(clk), .rst(rst), .no_cache(no_cache),
    .cpu_inst_req(cpu_inst_req), .cpu_inst_wr(cpu_inst_wr),
    .cpu_inst_size(cpu_inst_size), .cpu_inst_addr(cpu_inst_addr),
    .cpu_inst_wdata(cpu_inst_wdata), .cpu_inst_rdata(cpu_inst_rdata),
    .cpu_inst_addr_ok(cpu_inst_addr_ok), .cpu_inst_data_ok(cpu_inst_data_ok),
    .cache_inst_req(cache_inst_req), .cache_inst_wr(cache_inst_wr),
    .cache_inst_size(cache_inst_size), .cache_inst_addr(cache_inst_addr),
    .cache_inst_wdata(cache_inst_wdata), .cache_inst_rdata(cache_inst_rdata),
    .cache_inst_addr_ok(cache_inst_addr_ok), .cache_inst_data_ok(cache_inst_data_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive point is posedge+1; comparisons follow 1ns later.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic nc, input int aok_dly,
                       input int dat_dly, input bit combined, input logic [31:0] mem,
                       input bit exp_hit, input logic [31:0] exp_data, input string tag);
    cyc();
    cpu_inst_req = 1'b1; cpu_inst_addr = a; no_cache = nc;
    #1;
    chk({tag, ".addr_ok"}, {31'd0, cpu_inst_addr_ok}, 32'd1);
    chk({tag, ".req_no_data"}, {31'd0, cpu_inst_data_ok}, 32'd0);
    cyc();
    cpu_inst_req = 1'b0; cpu_inst_addr = 32'h0BAD_0000; no_cache = 1'b0;
    #1;
    if (exp_hit) begin
      chk({tag, ".hit_data_ok"}, {31'd0, cpu_inst_data_ok}, 32'd1);
      chk({tag, ".hit_rdata"}, cpu_inst_rdata, exp_data);
      chk({tag, ".hit_no_bus"}, {31'd0, cache_inst_req}, 32'd0);
      return;
    end
    chk({tag, ".lookup_miss"}, {31'd0, cpu_inst_data_ok}, 32'd0);
    cyc();
    for (int i = 0; i < aok_dly; i++) begin
      cpu_inst_req = 1'b1;
      #1;
      chk({tag, ".stall_req"}, {31'd0, cache_inst_req}, 32'd1);
      chk({tag, ".stall_addr"}, cache_inst_addr, a);
      chk({tag, ".stall_cpu_aok"}, {31'd0, cpu_inst_addr_ok}, 32'd0);
      cyc();
    end
    cpu_inst_req = 1'b0;
    cache_inst_addr_ok = 1'b1;
    if (combined) begin cache_inst_data_ok = 1'b1; cache_inst_rdata = mem; end
    #1;
    chk({tag, ".ds_req"}, {31'd0, cache_inst_req}, 32'd1);
    chk({tag, ".ds_addr"}, cache_inst_addr, a);
    chk({tag, ".ds_size"}, {30'd0, cache_inst_size}, 32'd2);
    if (!combined) begin
      cyc();
      cache_inst_addr_ok = 1'b0;
      #1;
      chk({tag, ".req_dropped"}, {31'd0, cache_inst_req}, 32'd0);
      for (int i = 0; i < dat_dly; i++) begin
        chk({tag, ".wait_no_data"}, {31'd0, cpu_inst_data_ok}, 32'd0);
        cyc();
      end
      cache_inst_data_ok = 1'b1; cache_inst_rdata = mem;
      #1;
    end
    chk({tag, ".miss_data_ok"}, {31'd0, cpu_inst_data_ok}, 32'd1);
    chk({tag, ".miss_rdata"}, cpu_inst_rdata, mem);
    cyc();
    cache_inst_addr_ok = 1'b0; cache_inst_data_ok = 1'b0; cache_inst_rdata = 32'hFFFF_FFFF;
    #1;
    chk({tag, ".done_data_ok"}, {31'd0, cpu_inst_data_ok}, 32'd0);
    chk({tag, ".done_rdata"}, cpu_inst_rdata, 32'd0);
  endtask

  initial begin
    #2;
    chk("rst.addr_ok", {31'd0, cpu_inst_addr_ok}, 32'd0);
    chk("rst.data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
    chk("rst.rdata", cpu_inst_rdata, 32'd0);
    chk("rst.ds_req", {31'd0, cache_inst_req}, 32'd0);
    chk("rst.ds_addr", cache_inst_addr, 32'd0);
    chk("rst.ds_size", {30'd0, cache_inst_size}, 32'd0);
    chk("rst.ds_wr", {31'd0, cache_inst_wr}, 32'd0);
    chk("rst.ds_wdata", cache_inst_wdata, 32'd0);
    cyc(); rst = 1'b0;

    fetch(32'h1FC0_0000, 1'b0, 0, 2, 1'b0, 32'h2408_0001, 1'b0, '0, "cold");
    fetch(32'h1FC0_0000, 1'b0, 0, 0, 1'b0, '0, 1'b1, 32'h2408_0001, "refetch");
    fetch(32'h1FC0_0100, 1'b0, 0, 1, 1'b0, 32'h3C1D_BFC0, 1'b0, '0, "conflict");
    fetch(32'h1FC0_0000, 1'b0, 0, 1, 1'b0, 32'h2408_0001, 1'b0, '0, "evicted");
    fetch(32'h1FC0_0000, 1'b0, 0, 0, 1'b0, '0, 1'b1, 32'h2408_0001, "rehit");
    fetch(32'h1FC0_0000, 1'b1, 0, 1, 1'b0, 32'hDEAD_BEEF, 1'b0, '0, "uncached");
    fetch(32'h1FC0_0000, 1'b0, 0, 0, 1'b0, '0, 1'b1, 32'h2408_0001, "after_nc");
    fetch(32'h1FC0_0004, 1'b0, 5, 1, 1'b0, 32'h1111_1111, 1'b0, '0, "stall");
    fetch(32'h1FC0_0004, 1'b0, 0, 0, 1'b0, '0, 1'b1, 32'h1111_1111, "stall_hit");
    fetch(32'h1FC0_0008, 1'b0, 1, 0, 1'b1, 32'h2222_2222, 1'b0, '0, "same_cyc");
    fetch(32'h1FC0_0008, 1'b0, 0, 0, 1'b0, '0, 1'b1, 32'h2222_2222, "same_cyc_hit");

    // Stray downstream data_ok while idle must be ignored.
    cyc();
    cache_inst_data_ok = 1'b1; cache_inst_rdata = 32'h5555_AAAA;
    #1;
    chk("stray.data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
    chk("stray.rdata", cpu_inst_rdata, 32'd0);
    cyc();
    cache_inst_data_ok = 1'b0;
    fetch(32'h1FC0_0004, 1'b0, 0, 0, 1'b0, '0, 1'b1, 32'h1111_1111, "stray_hit");

    // Reset while waiting for miss data.
    cyc();
    cpu_inst_req = 1'b1; cpu_inst_addr = 32'h1FC0_000C;
    cyc();
    cpu_inst_req = 1'b0;
    cyc();
    cache_inst_addr_ok = 1'b1;
    cyc();
    cache_inst_addr_ok = 1'b0;
    #1;
    chk("mw.ds_addr", cache_inst_addr, 32'h1FC0_000C);
    cyc();
    rst = 1'b1;
    #1;
    chk("mw_rst.ds_req", {31'd0, cache_inst_req}, 32'd0);
    chk("mw_rst.ds_addr", cache_inst_addr, 32'd0);
    chk("mw_rst.data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
    chk("mw_rst.addr_ok", {31'd0, cpu_inst_addr_ok}, 32'd0);
    cyc();
    rst = 1'b0;
    fetch(32'h1FC0_0004, 1'b0, 0, 1, 1'b0, 32'h3333_3333, 1'b0, '0, "post_rst");
    fetch(32'h1FC0_0004, 1'b0, 0, 0, 1'b0, '0, 1'b1, 32'h3333_3333, "post_rst_hit");

    repeat (2) cyc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
